// File: rtl/zbt_io_pkg.sv
// zbt_io_pkg: shared constants and helpers for the ZBT SRAM DQ data path.
//   MIN_LAT / MAX_LAT : legal range for the write and read latencies
//   CMD_RD / CMD_WR   : encoding of cmd_rw_n
//   LW()              : lane width in bits for a given bus width and lane count
package zbt_io_pkg;

  localparam int MIN_LAT = 1;
  localparam int MAX_LAT = 8;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

  function automatic int LW(input int dsize, input int bwsize);
    return dsize / bwsize;
  endfunction

endpackage

// File: rtl/zbt_io_delay.sv
// zbt_io_delay: WIDTH x DEPTH shift register with asynchronous clear.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high clear of every stage
//   i_d   : data entering stage 0 on each rising edge
//   o_q   : last stage (data presented DEPTH edges earlier)
module zbt_io_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/zbt_dq_io.sv
// zbt_dq_io: bidirectional DQ data path for a pipelined ZBT SRAM port.
//   clk, reset      : system clock, asynchronous active-high reset
//   cmd_valid       : command present this cycle
//   cmd_rw_n        : 1 = read, 0 = write
//   wr_data         : write data, sampled with the write command
//   wr_lane_en      : per-lane drive enable for the write
//   dq              : SRAM data bus (driven per lane in the write slot)
//   rd_data         : captured read data, held until the next capture
//   rd_valid        : one-cycle pulse per completed read
//   rd_outstanding  : reads accepted and not yet reported on rd_valid
//   err_collision   : sticky, a write slot coincided with a read slot
//
// Command handshake: valid-only. A command is taken on every rising edge
// where cmd_valid=1; there is no ready/backpressure, so the controller may
// issue one command of either type every cycle.
module zbt_dq_io
  import zbt_io_pkg::*;
#(
  parameter  int DSIZE  = 36,
  parameter  int BWSIZE = 4,
  parameter  int WR_LAT = 2,
  parameter  int RD_LAT = 2,
  localparam int CNTW   = $clog2(RD_LAT + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_rw_n,
  input  logic [DSIZE-1:0]  wr_data,
  input  logic [BWSIZE-1:0] wr_lane_en,
  inout  wire  [DSIZE-1:0]  dq,
  output logic [DSIZE-1:0]  rd_data,
  output logic              rd_valid,
  output logic [CNTW-1:0]   rd_outstanding,
  output logic              err_collision
);

  localparam int LANE_W = LW(DSIZE, BWSIZE);
  localparam int WP_W   = DSIZE + BWSIZE + 1;

  if (DSIZE % BWSIZE != 0) begin : g_bad_lanes
    $error("zbt_dq_io: DSIZE must be a multiple of BWSIZE");
  end
  if (WR_LAT < MIN_LAT || WR_LAT > MAX_LAT) begin : g_bad_wr_lat
    $error("zbt_dq_io: WR_LAT out of range");
  end
  if (RD_LAT < MIN_LAT || RD_LAT > MAX_LAT) begin : g_bad_rd_lat
    $error("zbt_dq_io: RD_LAT out of range");
  end

  logic [WP_W-1:0]   w_wr_in;
  logic [WP_W-1:0]   w_wr_out;
  logic              w_rd_in;
  logic              w_rd_out;
  logic              w_wr_slot;
  logic [BWSIZE-1:0] w_wr_lanes;
  logic [DSIZE-1:0]  w_wr_data;
  logic              w_collision;

  logic [BWSIZE-1:0] r_oe;
  logic [DSIZE-1:0]  r_wdata;
  logic              r_rd_slot;
  logic [DSIZE-1:0]  r_rd_data;
  logic              r_rd_valid;
  logic [CNTW-1:0]   r_cnt;
  logic              r_err;

  assign w_wr_in = {cmd_valid && (cmd_rw_n == CMD_WR), wr_lane_en, wr_data};
  assign w_rd_in = cmd_valid && (cmd_rw_n == CMD_RD);

  zbt_io_delay #(.WIDTH(WP_W), .DEPTH(WR_LAT)) u_wr_dly (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (w_wr_in),
    .o_q   (w_wr_out)
  );

  zbt_io_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_rd_dly (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (w_rd_in),
    .o_q   (w_rd_out)
  );

  assign {w_wr_slot, w_wr_lanes, w_wr_data} = w_wr_out;

  // Both delay-line outputs describe the slot that opens at the next edge,
  // so a write and a read token emerging together claim the same bus cycle.
  assign w_collision = w_wr_slot && w_rd_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oe       <= '0;
      r_wdata    <= '0;
      r_rd_slot  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_oe       <= (w_wr_slot && !w_collision) ? w_wr_lanes : '0;
      r_wdata    <= w_wr_data;
      r_rd_slot  <= w_rd_out;
      r_rd_valid <= r_rd_slot;
      if (r_rd_slot) begin
        r_rd_data <= dq;
      end
      r_err <= r_err || w_collision;
      // The decrement lands on the edge that raises rd_valid, which keeps
      // the count at or below RD_LAT+1 under back-to-back reads.
      case ({w_rd_in, r_rd_slot})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  for (genvar k = 0; k < BWSIZE; k++) begin : g_lane
    assign dq[k*LANE_W +: LANE_W] = r_oe[k] ? r_wdata[k*LANE_W +: LANE_W] : {LANE_W{1'bz}};
  end

  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign rd_outstanding = r_cnt;
  assign err_collision  = r_err;

endmodule

// File: tb/tb_zbt_dq_io.sv
// tb_zbt_dq_io: self-checking bench for zbt_dq_io.
//   u_dut   : DSIZE=36, BWSIZE=4, WR_LAT=2, RD_LAT=2 (main data path)
//   u_dut_c : same widths with WR_LAT=3, RD_LAT=2 (slot collision case)
module tb_zbt_dq_io;

  localparam logic [35:0] ALL1 = {36{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;

  // ---------------- main DUT ----------------
  logic        cmd_valid, cmd_rw_n;
  logic [35:0] wr_data;
  logic [3:0]  wr_lane_en;
  wire  [35:0] dq;
  logic [35:0] rd_data;
  logic        rd_valid;
  logic [1:0]  rd_outstanding;
  logic        err_collision;

  logic        tb_en = 1'b0;
  logic [35:0] tb_val = '0;

  assign dq = tb_en ? tb_val : {36{1'bz}};
  for (genvar g = 0; g < 36; g++) begin : g_pu
    pullup (dq[g]);
  end

  zbt_dq_io #(.DSIZE(36), .BWSIZE(4), .WR_LAT(2), .RD_LAT(2)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_rw_n       (cmd_rw_n),
    .wr_data        (wr_data),
    .wr_lane_en     (wr_lane_en),
    .dq             (dq),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_outstanding (rd_outstanding),
    .err_collision  (err_collision)
  );

  // ---------------- collision DUT ----------------
  logic        c_valid, c_rw_n;
  logic [35:0] c_wdata;
  logic [3:0]  c_lane;
  wire  [35:0] dq_c;
  logic [35:0] c_rd_data;
  logic        c_rd_valid;
  logic [1:0]  c_rd_out;
  logic        c_err;

  for (genvar g = 0; g < 36; g++) begin : g_pu_c
    pullup (dq_c[g]);
  end

  zbt_dq_io #(.DSIZE(36), .BWSIZE(4), .WR_LAT(3), .RD_LAT(2)) u_dut_c (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (c_valid),
    .cmd_rw_n       (c_rw_n),
    .wr_data        (c_wdata),
    .wr_lane_en     (c_lane),
    .dq             (dq_c),
    .rd_data        (c_rd_data),
    .rd_valid       (c_rd_valid),
    .rd_outstanding (c_rd_out),
    .err_collision  (c_err)
  );

  // ---------------- scoreboard state ----------------
  logic [35:0] exp_q[$];       // read data expected on rd_valid
  int          exp_cyc_q[$];   // cycle in which each rd_valid is due
  int          rd_e0_q[$];     // acceptance cycle of each read
  logic [35:0] exp_dq_a[int];  // bus value expected in a write slot
  logic [35:0] drv_a[int];     // value the bench drives in a read slot
  bit          mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [35:0] merge(input logic [35:0] d, input logic [3:0] le);
    logic [35:0] m;
    for (int k = 0; k < 4; k++) m[k*9 +: 9] = le[k] ? d[k*9 +: 9] : 9'h1FF;
    return m;
  endfunction

  function automatic logic [35:0] rand36();
    return {4'($urandom_range(0, 15)), 32'($urandom())};
  endfunction

  // Cycle counter plus the bench side of the read slots.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (drv_a.exists(cyc + 1)) begin
      tb_en  <= 1'b1;
      tb_val <= drv_a[cyc + 1];
    end else begin
      tb_en  <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs set at a falling edge are taken at the next rising edge E0,
  // after which cyc == E0. Write slot = E0+2, rd_valid cycle = E0+3.
  task automatic issue_write(input logic [35:0] d, input logic [3:0] le);
    cmd_valid  = 1'b1;
    cmd_rw_n   = 1'b0;
    wr_data    = d;
    wr_lane_en = le;
    exp_dq_a[cyc + 3] = merge(d, le);
    @(negedge clk);
  endtask

  task automatic issue_read(input logic [35:0] d);
    cmd_valid  = 1'b1;
    cmd_rw_n   = 1'b1;
    wr_data    = rand36();
    wr_lane_en = 4'($urandom_range(0, 15));
    drv_a[cyc + 3] = d;
    exp_q.push_back(d);
    exp_cyc_q.push_back(cyc + 4);
    rd_e0_q.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_models();
    exp_q.delete();
    exp_cyc_q.delete();
    rd_e0_q.delete();
    exp_dq_a.delete();
    drv_a.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [35:0] e_dq;
      bit          e_v;
      int          e_out;
      e_dq = exp_dq_a.exists(cyc) ? exp_dq_a[cyc] : (drv_a.exists(cyc) ? drv_a[cyc] : ALL1);
      chk("dq", 64'(dq), 64'(e_dq));
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      e_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      chk("rd_valid", 64'(rd_valid), 64'(e_v));
      if (e_v && rd_valid) begin
        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        void'(exp_cyc_q.pop_front());
      end
      e_out = 0;
      foreach (rd_e0_q[i]) if (rd_e0_q[i] <= cyc && cyc <= rd_e0_q[i] + 2) e_out++;
      chk("rd_outstanding", 64'(rd_outstanding), 64'(e_out));
      chk("err_collision", 64'(err_collision), 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_rw_n = 1'b0; wr_data = '0; wr_lane_en = '0;
    c_valid = 1'b0; c_rw_n = 1'b0; c_wdata = '0; c_lane = '0;
    repeat (3) @(negedge clk);

    chk("reset_dq", 64'(dq), 64'(ALL1));
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_out", 64'(rd_outstanding), 64'd0);
    chk("reset_err", 64'(err_collision), 64'd0);

    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    issue_write(36'h9_1234_5678, 4'hF);
    idle(5);
    issue_write(rand36(), 4'b0101);
    idle(5);
    issue_read(36'hA_BCDE_F012);
    idle(6);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue_write(rand36(), 4'($urandom_range(1, 15)));
      else            issue_read(rand36());
    end
    idle(6);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       idle(1);
        1:       issue_write(rand36(), 4'($urandom_range(0, 15)));
        default: issue_read(rand36());
      endcase
    end
    idle(6);
    chk("rd_drain", 64'(exp_q.size()), 64'd0);

    // Reset while a write is on the bus and two reads are in flight.
    issue_write(36'h5_A5A5_A5A5, 4'hF);
    issue_read(rand36());
    issue_read(rand36());
    cmd_valid = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("rst_pre_dq", 64'(dq), 64'h5_A5A5_A5A5);
    chk("rst_pre_out", 64'(rd_outstanding), 64'd2);
    reset = 1'b1;
    #1;
    chk("rst_dq", 64'(dq), 64'(ALL1));
    chk("rst_rd_out", 64'(rd_outstanding), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    clear_models();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    idle(8);
    mon_en = 1'b0;

    // WR_LAT=3 instance: a plain write first, then a colliding pair.
    c0 = cyc;
    c_valid = 1'b1; c_rw_n = 1'b0; c_wdata = 36'h3_0F0F_0F0F; c_lane = 4'hF;
    @(negedge clk);
    c_valid = 1'b0;
    while (cyc < c0 + 3) @(negedge clk);
    chk("c_wr_pre", 64'(dq_c), 64'(ALL1));
    @(negedge clk);
    chk("c_wr_slot", 64'(dq_c), 64'h3_0F0F_0F0F);
    @(negedge clk);
    chk("c_wr_post", 64'(dq_c), 64'(ALL1));
    chk("c_err_clean", 64'(c_err), 64'd0);
    repeat (2) @(negedge clk);

    c0 = cyc;
    c_valid = 1'b1; c_rw_n = 1'b0; c_wdata = 36'h0; c_lane = 4'hF;
    @(negedge clk);
    c_rw_n = 1'b1; c_wdata = rand36();
    @(negedge clk);
    c_valid = 1'b0;
    while (cyc < c0 + 3) @(negedge clk);
    chk("c_err_before", 64'(c_err), 64'd0);
    @(negedge clk);
    chk("c_coll_dq", 64'(dq_c), 64'(ALL1));
    chk("c_err_set", 64'(c_err), 64'd1);
    @(negedge clk);
    chk("c_rd_valid", 64'(c_rd_valid), 64'd1);
    chk("c_rd_data", 64'(c_rd_data), 64'(ALL1));
    @(negedge clk);
    chk("c_rd_pulse", 64'(c_rd_valid), 64'd0);
    chk("c_rd_out", 64'(c_rd_out), 64'd0);
    repeat (4) @(negedge clk);
    chk("c_err_held", 64'(c_err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
